// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide scheduler: op codes, FSM states,
// default latencies and a small magnitude helper used by the divider.
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned 2^31.
  function automatic logic [31:0] md_abs(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/md_sched_if.sv
// E-stage / hazard-unit side of the multiply/divide scheduler.
interface md_sched_if;
  logic        md_start;
  logic [1:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mthi;
  logic        mtlo;
  logic        md_use_D;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_md;

  modport master (
    output md_start, md_op, src_a, src_b, mthi, mtlo, md_use_D,
    input  hi, lo, busy, stall_md
  );

  modport slave (
    input  md_start, md_op, src_a, src_b, mthi, mtlo, md_use_D,
    output hi, lo, busy, stall_md
  );
endinterface

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath: (op, a, b) -> {hi, lo} plus a
// divide-by-zero flag. Signed division works on magnitudes and restores signs.
module md_arith
  import md_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o,
  output logic        div_zero_o
);

  logic [63:0] res;
  logic        is_signed;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] safe_b;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        neg_q;
  logic        neg_r;

  // Select product or quotient/remainder; a zero divisor is replaced by 1 to keep the divider defined
  always_comb begin
    res       = '0;
    is_signed = 1'b0;
    mag_a     = '0;
    mag_b     = '0;
    safe_b    = 32'd1;
    quo       = '0;
    rem       = '0;
    neg_q     = 1'b0;
    neg_r     = 1'b0;
    unique case (md_op_e'(op_i))
      MD_MULT:  res = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
      MD_MULTU: res = {32'b0, a_i} * {32'b0, b_i};
      MD_DIV, MD_DIVU: begin
        is_signed = (md_op_e'(op_i) == MD_DIV);
        mag_a     = is_signed ? md_abs(a_i) : a_i;
        mag_b     = is_signed ? md_abs(b_i) : b_i;
        safe_b    = (mag_b == '0) ? 32'd1 : mag_b;
        quo       = mag_a / safe_b;
        rem       = mag_a % safe_b;
        neg_q     = is_signed & (a_i[31] ^ b_i[31]);
        neg_r     = is_signed & a_i[31];
        res       = {neg_r ? (~rem + 32'd1) : rem, neg_q ? (~quo + 32'd1) : quo};
      end
      default: res = '0;
    endcase
  end

  assign res_hi_o   = res[63:32];
  assign res_lo_o   = res[31:0];
  assign div_zero_o = op_i[1] & (b_i == '0);

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler: owns HI/LO, runs each mult/div for a fixed
// latency, and stalls any D-stage HI/LO consumer while an op is in flight.
module md_sched
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input logic       clk,
  input logic       reset,
  md_sched_if.slave md
);

  localparam int unsigned MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW    = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  md_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d;
  logic [31:0]   pend_lo_q, pend_lo_d;
  logic          pend_zero_q, pend_zero_d;

  logic [31:0]   res_hi;
  logic [31:0]   res_lo;
  logic          div_zero;

  md_arith u_arith (
    .op_i       (md.md_op),
    .a_i        (md.src_a),
    .b_i        (md.src_b),
    .res_hi_o   (res_hi),
    .res_lo_o   (res_lo),
    .div_zero_o (div_zero)
  );

  // State, countdown, pending result and architectural HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= MD_IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      pend_hi_q   <= '0;
      pend_lo_q   <= '0;
      pend_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      pend_zero_q <= pend_zero_d;
    end
  end

  // Launch from IDLE (start beats mthi/mtlo), count down in RUN, commit on cnt==0
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    pend_zero_d = pend_zero_q;
    unique case (state_q)
      MD_IDLE: begin
        if (md.md_start) begin
          pend_hi_d   = res_hi;
          pend_lo_d   = res_lo;
          pend_zero_d = div_zero;
          cnt_d       = CW'(md.md_op[1] ? DIV_CYCLES - 1 : MULT_CYCLES - 1);
          state_d     = MD_RUN;
        end else begin
          if (md.mthi) hi_d = md.src_a;
          if (md.mtlo) lo_d = md.src_a;
        end
      end
      MD_RUN: begin
        if (cnt_q == '0) begin
          if (!pend_zero_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign md.busy     = (state_q == MD_RUN);
  assign md.stall_md = md.md_use_D & (md.busy | md.md_start);

endmodule
